// File: rtl/uart_rx_sipo.sv
// UART receiver: synchronises the rx line, tracks bit timing with oversampling
// ticks and rebuilds LSB-first frames into a parallel word with parity/stop checks.
module uart_rx_sipo #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rx_meta;
    logic                    r_rxs;
    logic [TW-1:0]           r_tick_cnt;
    logic [BW-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_armed;
    logic                    r_par_err_pend;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_data_valid;
    logic                    r_parity_err;
    logic                    r_frame_err;

    logic                    w_cnt_clr;
    logic                    w_cnt_inc;
    logic                    w_bit_clr;
    logic                    w_shift;
    logic                    w_par_smp;
    logic                    w_stop_smp;
    logic                    w_arm_set;
    logic                    w_par_calc;

    // Two-flop synchroniser; everything downstream uses r_rxs only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        w_arm_set   = 1'b0;
        if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_rxs) begin
                        w_arm_set = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = S_START;
                        w_cnt_clr   = 1'b1;
                    end
                end
                S_START: begin
                    // Mid start bit: a high line here means the falling edge was a glitch.
                    if (r_tick_cnt == HALF_M1) begin
                        w_cnt_clr = 1'b1;
                        if (r_rxs) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_bit_clr   = 1'b1;
                        end
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == FULL_M1) begin
                        w_cnt_clr = 1'b1;
                        w_shift   = 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_tick_cnt == FULL_M1) begin
                        w_cnt_clr   = 1'b1;
                        w_par_smp   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == FULL_M1) begin
                        w_cnt_clr   = 1'b1;
                        w_stop_smp  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign w_par_calc = (^r_shift) ^ ODD_BIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_armed        <= 1'b1;
            r_par_err_pend <= 1'b0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_parity_err   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_cnt_clr) begin
                r_tick_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_par_smp) begin
                r_par_err_pend <= (r_rxs != w_par_calc);
            end
            if (w_arm_set) begin
                r_armed <= 1'b1;
            end
            // A low stop bit disarms IDLE so a held break yields only one frame.
            if (w_stop_smp) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
                r_parity_err <= (PARITY_EN != 0) ? r_par_err_pend : 1'b0;
                r_frame_err  <= ~r_rxs;
                if (!r_rxs) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_shift <= {r_rxs, r_shift[DATA_WIDTH-1:1]};
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: one instance with parity (even), one without.
module tb_uart_rx_sipo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;
    int tcnt = 0;
    int base;

    int         vcnt_a = 0, vcnt_b = 0, wide_a = 0, wide_b = 0;
    logic [7:0] words_a [64];
    logic [7:0] words_b [64];
    logic       prev_dv_a = 1'b0, prev_dv_b = 1'b0, prev_busy_a = 1'b0;
    logic       busy_at_dv_a = 1'b1, busy_pre_dv_a = 1'b0;

    uart_rx_sipo #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_a),
        .data_out(data_a), .data_valid(dv_a), .parity_err(perr_a),
        .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx_sipo #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_b),
        .data_out(data_b), .data_valid(dv_b), .parity_err(perr_b),
        .frame_err(ferr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Tick every 4th clock, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            tcnt++;
            sample_tick = (tcnt % 4 == 0);
        end
    end

    always @(negedge clk) begin
        if (dv_a) begin
            if (prev_dv_a) begin
                wide_a++;
            end else begin
                vcnt_a++;
                words_a[vcnt_a % 64] = data_a;
                busy_at_dv_a  = busy_a;
                busy_pre_dv_a = prev_busy_a;
            end
        end
        if (dv_b) begin
            if (prev_dv_b) begin
                wide_b++;
            end else begin
                vcnt_b++;
                words_b[vcnt_b % 64] = data_b;
            end
        end
        prev_dv_a   = dv_a;
        prev_dv_b   = dv_b;
        prev_busy_a = busy_a;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_rx(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit to_b);
        set_rx(to_b, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(to_b, d[i]);
            wait_ticks(16);
        end
        if (!to_b) begin
            set_rx(to_b, par);
            wait_ticks(16);
        end
        set_rx(to_b, stop);
        wait_ticks(16);
        set_rx(to_b, 1'b1);
    endtask

    initial begin
        logic [7:0] partial;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data_out", data_a, 8'h00);
        chk("rst_data_valid", dv_a, 1'b0);
        chk("rst_parity_err", perr_a, 1'b0);
        chk("rst_frame_err", ferr_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        wait_ticks(4);

        // 0xA5 with correct even parity
        base = vcnt_a;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("a5_count", vcnt_a, base + 1);
        chk("a5_word", words_a[(base + 1) % 64], 8'hA5);
        chk("a5_data_out", data_a, 8'hA5);
        chk("a5_parity_err", perr_a, 1'b0);
        chk("a5_frame_err", ferr_a, 1'b0);
        chk("a5_busy_at_valid", busy_at_dv_a, 1'b0);
        chk("a5_busy_before_valid", busy_pre_dv_a, 1'b1);

        // 0x3C with wrong parity bit
        base = vcnt_a;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_ticks(4);
        chk("3c_count", vcnt_a, base + 1);
        chk("3c_data_out", data_a, 8'h3C);
        chk("3c_parity_err", perr_a, 1'b1);
        chk("3c_frame_err", ferr_a, 1'b0);

        // 0x81 with low stop bit, then break for three frame times
        base = vcnt_a;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        set_rx(1'b0, 1'b0);
        wait_ticks(3 * 11 * 16);
        chk("brk_count", vcnt_a, base + 1);
        chk("brk_data_out", data_a, 8'h81);
        chk("brk_frame_err", ferr_a, 1'b1);
        chk("brk_parity_err", perr_a, 1'b0);
        chk("brk_busy", busy_a, 1'b0);
        set_rx(1'b0, 1'b1);
        wait_ticks(20);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("post_brk_count", vcnt_a, base + 2);
        chk("post_brk_data_out", data_a, 8'h55);
        chk("post_brk_frame_err", ferr_a, 1'b0);
        chk("post_brk_parity_err", perr_a, 1'b0);
        wait_ticks(10);

        // Start-bit glitch: low for 4 ticks only
        base = vcnt_a;
        set_rx(1'b0, 1'b0);
        wait_ticks(2);
        chk("glitch_busy_start", busy_a, 1'b1);
        wait_ticks(2);
        set_rx(1'b0, 1'b1);
        wait_ticks(2);
        chk("glitch_busy_mid", busy_a, 1'b1);
        wait_ticks(6);
        chk("glitch_busy_idle", busy_a, 1'b0);
        chk("glitch_no_valid", vcnt_a, base);
        wait_ticks(10);

        // Back-to-back frames with parity
        base = vcnt_a;
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("b2b_count", vcnt_a, base + 2);
        chk("b2b_word0", words_a[(base + 1) % 64], 8'h00);
        chk("b2b_word1", words_a[(base + 2) % 64], 8'hFF);
        chk("b2b_parity_err", perr_a, 1'b0);
        chk("b2b_frame_err", ferr_a, 1'b0);

        // Back-to-back frames without parity
        base = vcnt_b;
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        wait_ticks(4);
        chk("nopar_b2b_count", vcnt_b, base + 2);
        chk("nopar_b2b_word0", words_b[(base + 1) % 64], 8'h00);
        chk("nopar_b2b_word1", words_b[(base + 2) % 64], 8'hFF);
        chk("nopar_parity_err", perr_b, 1'b0);
        chk("nopar_frame_err", ferr_b, 1'b0);

        // Reset in the middle of the data bits of 0xF0
        base = vcnt_a;
        partial = 8'hF0;
        set_rx(1'b0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            set_rx(1'b0, partial[i]);
            wait_ticks(16);
        end
        wait_ticks(5);
        chk("pre_rst_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data_out", data_a, 8'h00);
        chk("mid_rst_data_valid", dv_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_parity_err", perr_a, 1'b0);
        chk("mid_rst_frame_err", ferr_a, 1'b0);
        set_rx(1'b0, 1'b1);
        wait_ticks(3);
        rst_n = 1'b1;
        wait_ticks(4);
        chk("mid_rst_no_valid", vcnt_a, base);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        chk("post_rst_count", vcnt_a, base + 1);
        chk("post_rst_data_out", data_a, 8'h0F);
        chk("post_rst_parity_err", perr_a, 1'b0);
        chk("post_rst_frame_err", ferr_a, 1'b0);

        chk("valid_width_a", wide_a, 0);
        chk("valid_width_b", wide_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
